// File: rtl/rom_loader.sv
// rom_loader: writer side of the sc1_cpu instruction-ROM interface.
// Parses a framed byte stream (SYNC, LEN, 4*N data bytes, CSUM), assembles
// little-endian 32-bit words, writes them to instruction RAM and keeps the
// CPU in reset until a frame whose XOR checksum matches has been loaded.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   rx_data    incoming byte
//   rx_valid   rx_data valid
//   rx_ready   byte accepted when rx_valid && rx_ready at posedge clk
//   rom_we     one-cycle instruction RAM write strobe
//   rom_waddr  instruction RAM write address
//   rom_wdata  instruction RAM write data
//   cpu_reset  active-high reset to sc1_cpu
//   busy       frame in progress
//   error      last frame failed (checksum or timeout)
module rom_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  rom_we,
  output logic [ADDR_WIDTH-1:0] rom_waddr,
  output logic [DATA_WIDTH-1:0] rom_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  error
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  rom_we_q, rom_we_d;
  logic [ADDR_WIDTH-1:0] rom_waddr_q, rom_waddr_d;
  logic [DATA_WIDTH-1:0] rom_wdata_q, rom_wdata_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  busy_q, busy_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [1:0]            bidx_q, bidx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [7:0]            xor_q, xor_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  accept;

  assign accept = rx_valid && rx_ready_q;

  always_comb begin
    state_d     = state_q;
    rx_ready_d  = 1'b1;
    rom_we_d    = 1'b0;
    rom_waddr_d = rom_waddr_q;
    rom_wdata_d = rom_wdata_q;
    cpu_reset_d = cpu_reset_q;
    busy_d      = busy_q;
    error_d     = error_q;
    addr_d      = addr_q;
    last_d      = last_q;
    bidx_d      = bidx_q;
    word_d      = word_q;
    xor_d       = xor_q;
    tcnt_d      = tcnt_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (accept && rx_data == SYNC_BYTE) begin
          state_d     = S_LEN;
          busy_d      = 1'b1;
          error_d     = 1'b0;
          cpu_reset_d = 1'b1;
          tcnt_d      = '0;
        end
      end
      S_LEN, S_DATA, S_CSUM: begin
        if (accept) begin
          tcnt_d = '0;
          case (state_q)
            S_LEN: begin
              // Store the index of the final word; LEN==0 selects a full image.
              last_d  = (rx_data == 8'd0) ? '1 : ADDR_WIDTH'(rx_data - 8'd1);
              addr_d  = '0;
              bidx_d  = '0;
              xor_d   = '0;
              state_d = S_DATA;
            end
            S_DATA: begin
              // Right-shift so the first byte of a word lands in bits [7:0].
              word_d = {rx_data, word_q[DATA_WIDTH-1:8]};
              xor_d  = xor_q ^ rx_data;
              bidx_d = bidx_q + 2'd1;
              if (bidx_q == 2'd3) begin
                rom_we_d    = 1'b1;
                rom_waddr_d = addr_q;
                rom_wdata_d = word_d;
                if (addr_q == last_q) begin
                  state_d = S_CSUM;
                end else begin
                  addr_d = addr_q + 1'b1;
                end
              end
            end
            default: begin
              busy_d = 1'b0;
              if (rx_data == xor_q) begin
                state_d     = S_DONE;
                cpu_reset_d = 1'b0;
                error_d     = 1'b0;
              end else begin
                state_d = S_ERR;
                error_d = 1'b1;
              end
            end
          endcase
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          // This idle cycle is the TIMEOUT-th one since the last accepted byte.
          state_d     = S_ERR;
          error_d     = 1'b1;
          busy_d      = 1'b0;
          cpu_reset_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rx_ready_q  <= 1'b0;
      rom_we_q    <= 1'b0;
      rom_waddr_q <= '0;
      rom_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      addr_q      <= '0;
      last_q      <= '0;
      bidx_q      <= '0;
      word_q      <= '0;
      xor_q       <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= rx_ready_d;
      rom_we_q    <= rom_we_d;
      rom_waddr_q <= rom_waddr_d;
      rom_wdata_q <= rom_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      bidx_q      <= bidx_d;
      word_q      <= word_d;
      xor_q       <= xor_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign rom_we    = rom_we_q;
  assign rom_waddr = rom_waddr_q;
  assign rom_wdata = rom_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign error     = error_q;

endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;

  localparam int TO = 16;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rom_we;
  logic [7:0]  rom_waddr;
  logic [31:0] rom_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        error;

  rom_loader #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rom_we   (rom_we),
    .rom_waddr(rom_waddr),
    .rom_wdata(rom_wdata),
    .cpu_reset(cpu_reset),
    .busy     (busy),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: frame position counter over the byte stream.
  // m_pos < 0: outside a frame; 0: next byte is LEN; 1..4N: data; 4N+1: CSUM.
  int          m_pos = -1;
  int          m_n   = 0;
  int          m_idle = 0;
  logic [7:0]  m_x;
  logic [7:0]  m_b [4];
  logic        started = 1'b0;
  logic        exp_ready, exp_we, exp_cpu, exp_busy, exp_err;
  logic [7:0]  exp_waddr;
  logic [31:0] exp_wdata;

  always @(posedge clk) begin
    logic acc;
    int   k;
    started <= 1'b1;
    if (!reset) begin
      m_pos = -1; m_idle = 0;
      exp_ready = 1'b0; exp_we = 1'b0; exp_cpu = 1'b1; exp_busy = 1'b0; exp_err = 1'b0;
      exp_waddr = 8'h00; exp_wdata = 32'h0;
    end else begin
      acc = rx_valid && exp_ready;
      exp_ready = 1'b1;
      exp_we = 1'b0;
      if (m_pos < 0) begin
        if (acc && rx_data == 8'hA5) begin
          m_pos = 0; m_idle = 0;
          exp_busy = 1'b1; exp_err = 1'b0; exp_cpu = 1'b1;
        end
      end else if (acc) begin
        m_idle = 0;
        if (m_pos == 0) begin
          m_n = (rx_data == 8'd0) ? 256 : int'(rx_data);
          m_x = 8'h00;
          m_pos = 1;
        end else if (m_pos <= 4 * m_n) begin
          k = (m_pos - 1) % 4;
          m_b[k] = rx_data;
          m_x = m_x ^ rx_data;
          if (k == 3) begin
            exp_we = 1'b1;
            exp_waddr = 8'((m_pos - 1) / 4);
            exp_wdata = {m_b[3], m_b[2], m_b[1], m_b[0]};
          end
          m_pos++;
        end else begin
          exp_busy = 1'b0;
          if (rx_data == m_x) exp_cpu = 1'b0;
          else exp_err = 1'b1;
          m_pos = -1;
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          exp_err = 1'b1; exp_busy = 1'b0; exp_cpu = 1'b1;
          m_pos = -1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus a write log.
  int         wr_cnt = 0;
  logic [7:0] wr_last;

  always @(negedge clk) begin
    if (started) begin
      total++;
      if ({rx_ready, rom_we, cpu_reset, busy, error} !== {exp_ready, exp_we, exp_cpu, exp_busy, exp_err}) begin
        bad++;
        $display("FAIL ctl t=%0t got rdy/we/cpu/busy/err=%b expected=%b", $time,
                 {rx_ready, rom_we, cpu_reset, busy, error}, {exp_ready, exp_we, exp_cpu, exp_busy, exp_err});
      end
      if (exp_we) begin
        total++;
        if (rom_waddr !== exp_waddr || rom_wdata !== exp_wdata) begin
          bad++;
          $display("FAIL wr t=%0t got %h:%h expected %h:%h", $time, rom_waddr, rom_wdata, exp_waddr, exp_wdata);
        end
      end
      if (rom_we === 1'b1) begin
        wr_cnt++;
        wr_last = rom_waddr;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_vals", {20'h0, rx_ready, rom_we, cpu_reset, busy, error, 7'h0}, {20'h0, 5'b00100, 7'h0});
    chk("rst_addr_data", {rom_waddr, rom_wdata[23:0]} | {24'h0, rom_wdata[31:24]}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    idle(1);
  endtask

  task automatic frame1(input logic [7:0] cs);
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    #1;
    chk("t1_we", {31'h0, rom_we}, 32'h1);
    chk("t1_addr", {24'h0, rom_waddr}, 32'h0);
    chk("t1_data", rom_wdata, 32'h12345678);
    send_byte(cs);
    #1;
  endtask

  initial begin
    int base;
    logic [7:0] x, b;
    int len;
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("init_rst", {27'h0, rx_ready, rom_we, cpu_reset, busy, error}, 32'b00100);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", {31'h0, rx_ready}, 32'h1);
    idle(2);

    // 1: single-word frame with correct checksum
    frame1(8'h08);
    chk("t1_release", {29'h0, cpu_reset, error, busy}, 32'b000);
    idle(3);

    // 2: LEN=0 full image
    base = wr_cnt;
    send_byte(8'hA5); send_byte(8'h00);
    for (int k = 0; k < 256; k++)
      for (int j = 0; j < 4; j++)
        send_byte(8'(k));
    #1;
    chk("t2_last_addr", {24'h0, rom_waddr}, 32'hFF);
    chk("t2_last_data", rom_wdata, 32'hFFFFFFFF);
    send_byte(8'h00);
    #1;
    chk("t2_release", {29'h0, cpu_reset, error, busy}, 32'b000);
    idle(4);
    chk("t2_wr_count", 32'(wr_cnt - base), 32'd256);
    chk("t2_wr_last", {24'h0, wr_last}, 32'hFF);

    // 3: bad checksum, then good frame
    frame1(8'h09);
    chk("t3_err", {29'h0, cpu_reset, error, busy}, 32'b110);
    idle(2);
    frame1(8'h08);
    chk("t3_recover", {29'h0, cpu_reset, error, busy}, 32'b000);
    idle(2);

    // 4: timeout after a partial word
    base = wr_cnt;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (TO - 1) @(posedge clk);
    #1;
    chk("t4_err_early", {31'h0, error}, 32'h0);
    @(posedge clk);
    #1;
    chk("t4_err_on_time", {29'h0, cpu_reset, error, busy}, 32'b110);
    chk("t4_no_write", 32'(wr_cnt - base), 32'd0);
    idle(2);

    // 5: junk before sync, in-frame sync byte as data
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    #1;
    chk("t5_data", rom_wdata, 32'h000000A5);
    send_byte(8'hA5);
    #1;
    chk("t5_release", {29'h0, cpu_reset, error, busy}, 32'b000);
    send_byte(8'hA5);
    #1;
    chk("t5_restart", {29'h0, cpu_reset, error, busy}, 32'b101);
    idle(TO + 3);

    // 6: reset after the 2nd data byte, then a clean frame
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02);
    pulse_reset();
    frame1(8'h08);
    chk("t6_release", {29'h0, cpu_reset, error, busy}, 32'b000);
    idle(2);

    // Randomized frames: junk, random lengths, gaps, bad checksums, resets
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 2) == 0) begin
        b = 8'($urandom);
        send_byte(b == 8'hA5 ? 8'h3C : b);
      end
      send_byte(8'hA5);
      len = $urandom_range(1, 5);
      send_byte(8'(len));
      x = 8'h00;
      for (int i = 0; i < 4 * len; i++) begin
        b = 8'($urandom);
        x = x ^ b;
        send_byte(b);
        if ($urandom_range(0, 80) == 0) pulse_reset();
        else if ($urandom_range(0, 50) == 0) idle(TO + 1);
        else idle($urandom_range(0, 2));
      end
      send_byte(($urandom_range(0, 3) == 0) ? (x ^ 8'h40) : x);
      idle($urandom_range(0, 3));
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Writer side of the sc1_cpu instruction-ROM interface.
- Receives a framed byte stream from a byte source (UART receiver or host bridge) over a valid/ready handshake.
- Assembles 32-bit instruction words and writes them into instruction RAM through a write port.
- Holds sc1_cpu in reset while loading and releases it only after a load whose checksum verifies.

Parameters:
ADDR_WIDTH, 8, instruction RAM address width; max image is 2^ADDR_WIDTH words
DATA_WIDTH, 32, instruction word width; must be 32 (4 bytes per word)
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT, 50000, max clk cycles between accepted bytes inside a frame

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts byte; transfer occurs when rx_valid && rx_ready at posedge clk
rom_we  output  1  instruction RAM write strobe, one-cycle pulse
rom_waddr  output  ADDR_WIDTH  write address
rom_wdata  output  DATA_WIDTH  write data
cpu_reset  output  1  active-high reset to sc1_cpu
busy  output  1  frame in progress
error  output  1  last frame failed (checksum or timeout)

Behaviour:
- All outputs are registered. reset==0 at a posedge forces:
  - state IDLE
  - rx_ready=0, rom_we=0, rom_waddr=0, rom_wdata=0
  - cpu_reset=1, busy=0, error=0
  - internal counters cleared; any partial word discarded
- rx_ready=1 every cycle after the first cycle out of reset; the loader never stalls.
- Frame format: SYNC_BYTE, LEN, 4*N data bytes, CSUM.
  - N = LEN, except LEN==0 means N=2^ADDR_WIDTH.
  - Words are little-endian: the first byte of each word goes to bits [7:0].
  - CSUM is the XOR of all data bytes; SYNC and LEN are excluded.
- IDLE:
  - Non-SYNC bytes are accepted and discarded.
  - SYNC -> LEN; on the next cycle: busy=1, error=0, cpu_reset=1.
- LEN: the accepted byte loads the word count; addr=0, byte index=0, xor=0 -> DATA.
- DATA:
  - Each accepted byte is shifted into the word register and XORed into xor.
  - On acceptance of the 4th byte of a word, the next cycle drives rom_we=1, rom_waddr=addr, rom_wdata=assembled word, for exactly one cycle. addr then increments.
  - After the Nth word's 4th byte -> CSUM.
  - addr never wraps within a frame: N=2^ADDR_WIDTH ends at addr 2^ADDR_WIDTH-1.
- CSUM:
  - byte==xor -> DONE. Next cycle: cpu_reset=0, busy=0, error=0.
  - Otherwise -> ERR. Next cycle: error=1, busy=0, cpu_reset stays 1.
- DONE / ERR:
  - Non-SYNC bytes are ignored.
  - SYNC restarts exactly as from IDLE: cpu_reset=1 next cycle, error cleared.
- Timeout:
  - In LEN/DATA/CSUM, a counter increments each cycle with no accepted byte and clears on every accepted byte.
  - When the counter reaches TIMEOUT -> ERR with error=1, cpu_reset=1. No rom_we is issued for the partial word.
- Words already written before an error are not rolled back.
- Reset mid-frame aborts immediately. No rom_we may be issued in the cycle after reset is sampled low.
- SYNC_BYTE inside LEN/DATA/CSUM is ordinary data, not a restart.

Test Plan:
1. Bytes A5,01,78,56,34,12,08 back-to-back -> single rom_we with rom_waddr=0x00 and rom_wdata=0x12345678, one cycle after byte 0x12. Then cpu_reset 1->0, error=0, busy=0.
2. A5,00, then 1024 bytes (word k = {k,k,k,k}), then correct CSUM -> 256 writes at addrs 0x00..0xFF in order, no write after 0xFF, cpu_reset released.
3. Case 1 with CSUM=0x09 -> write at addr 0 still occurs. error=1, cpu_reset stays 1. A following correct frame clears error and releases cpu_reset.
4. TIMEOUT=16: A5,02,11,22 then rx_valid low -> error=1 exactly 16 cycles after byte 0x22 is accepted, no rom_we, busy=0.
5. Bytes 00,FF,A5,01,A5,00,00,00,A5 -> leading 00,FF ignored. In-frame A5 is treated as data, giving rom_wdata=0x000000A5. CSUM A5 matches. After DONE, another A5 reasserts cpu_reset on the next cycle.
6. reset low for 1 cycle after the 2nd data byte of a frame -> next cycle shows all reset values, no rom_we. A new full frame afterwards loads correctly from addr 0.
